axis_keep_packer: RTL and testbench
===================================

AXIS_KEEP_PACKER -- requirements
Module: axis_keep_packer

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32, stream data width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter TKEEP_WIDTH, default TDATA_WIDTH/8, byte lanes per beat (N below).
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic rises on aclk.
REQ-004 SHALL have port aresetn, input, 1, reset: one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports s_axis_tdata (input, TDATA_WIDTH), s_axis_tkeep (input, N), s_axis_tlast (input, 1) and s_axis_tvalid (input, 1), the sparse input stream.
REQ-006 SHALL have port s_axis_tready, output, 1, input accept.
REQ-007 SHALL have ports m_axis_tdata (output, TDATA_WIDTH), m_axis_tkeep (output, N), m_axis_tlast (output, 1) and m_axis_tvalid (output, 1), the packed output stream.
REQ-008 SHALL have port m_axis_tready, input, 1, output accept.

Function
REQ-009 SHALL remove null byte lanes (tkeep=0) and pack the valid bytes contiguously into full beats, preserving byte order (ascending lane order within a beat, then beat order).
REQ-010 SHALL hold the bytes in a 2N-byte buffer with count register cnt (0..2N) and a last_pending flag.
REQ-011 Input handshake: s_axis_tready = !last_pending && (cnt <= N); accept = s_axis_tvalid && s_axis_tready.
REQ-012 Output valid: m_axis_tvalid = (cnt >= N) || last_pending; fire = m_axis_tvalid && m_axis_tready.
REQ-013 m_axis_tdata SHALL be buffer bytes 0..N-1, with lanes at index >= cnt driven to zero.
REQ-014 m_axis_tkeep SHALL be the low min(cnt,N) bits set and all others clear.
REQ-015 m_axis_tlast SHALL be last_pending && (cnt <= N).
REQ-016 On fire, SHALL remove out_n = min(cnt,N) bytes and shift the remaining bytes down to index 0.
REQ-017 On accept, SHALL append the in_n = popcount(s_axis_tkeep) valid bytes at index cnt - out_n (out_n = 0 when no fire).
REQ-018 Next cnt SHALL be cnt - out_n + in_n; simultaneous accept and fire SHALL be supported in the same cycle.
REQ-019 An accepted beat with s_axis_tlast=1 SHALL set last_pending, blocking input until the packet is flushed.
REQ-020 A fire with m_axis_tlast=1 SHALL clear last_pending and leave cnt=0.
REQ-021 An accepted beat with tkeep all zero and tlast=0 SHALL change nothing except being consumed.
REQ-022 If last_pending and cnt=0, SHALL emit one beat with tkeep=0, tdata=0, tlast=1.
REQ-023 Latency: a byte accepted in cycle t SHALL be visible on m_axis no earlier than cycle t+1; outputs are functions of registers only, with no combinational path from s_axis to m_axis.
REQ-024 Once asserted, m_axis_tvalid SHALL stay high, with tdata, tkeep and tlast stable, until fire.
REQ-025 Only the last beat of a packet SHALL carry a partial tkeep; all other output beats SHALL have tkeep all ones.

Reset
REQ-026 While aresetn=0 at a rising aclk edge, SHALL set cnt=0, clear last_pending and clear buffer contents to zero.
REQ-027 During and after reset, SHALL give m_axis_tvalid=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tdata=0 and s_axis_tready=1.
REQ-028 Reset mid-packet SHALL discard all buffered bytes, and no partial beat SHALL be emitted afterwards.

Verification (N=4)
REQ-029 Reset check: assert aresetn=0 for 2 cycles, then release -> m_axis_tvalid=0, s_axis_tready=1, cnt=0.
REQ-030 Join two halves: send tdata 0xAABB2211 with tkeep 0011, then 0x4433CCDD with tkeep 1100 and tlast=1 -> one output beat 0x44332211, tkeep 1111, tlast=1.
REQ-031 Sparse single beat: send 0x00CC00AA with tkeep 0101 and tlast=1 -> output 0x0000CCAA, tkeep 0011, tlast=1.
REQ-032 Backpressure: hold m_axis_tready=0 and offer 4 full beats 0x03020100, 0x07060504, ... -> s_axis_tready drops after 2 beats accepted (cnt=8); after release, the outputs arrive in order with none lost or duplicated.
REQ-033 Null last: send tkeep 0000 with tlast=1 at cnt=0 -> one beat with tkeep 0000, tdata 0, tlast=1, then s_axis_tready returns to 1.
REQ-034 Reset mid-packet: accept 6 bytes, pulse aresetn=0 for 1 cycle -> no output beat appears, cnt=0, and the next packet is packed from lane 0.

Source files
------------

// File: rtl/axis_keep_packer.sv
// AXI-Stream byte packer: drops null byte lanes and re-packs the surviving bytes
// into full beats through a 2N-byte shift buffer.
module axis_keep_packer #(
   parameter int TDATA_WIDTH = 32,
   parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready
);
   localparam int N  = TKEEP_WIDTH;
   localparam int B  = 2 * N;
   localparam int CW = $clog2(B + 1);
   localparam int AW = $clog2(B);
   localparam int PW = $clog2(N);
   localparam logic [CW-1:0] N_C = CW'(N);

   logic [7:0]    r_buf [B];
   logic [CW-1:0] r_cnt;
   logic          r_last;

   logic [7:0]    w_pack [N];
   logic [7:0]    w_buf_next [B];
   logic [CW-1:0] w_in_n;
   logic [CW-1:0] w_out_n;
   logic [CW-1:0] w_shift;
   logic [CW-1:0] w_base;
   logic          w_accept;
   logic          w_fire;

   assign s_axis_tready = !r_last && (r_cnt <= N_C);
   assign m_axis_tvalid = (r_cnt >= N_C) || r_last;
   assign m_axis_tlast  = r_last && (r_cnt <= N_C);
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign w_fire        = m_axis_tvalid && m_axis_tready;
   assign w_out_n       = (r_cnt >= N_C) ? N_C : r_cnt;
   assign w_shift       = w_fire ? w_out_n : '0;
   assign w_base        = r_cnt - w_shift;

   // Lanes beyond the fill level read as zero, so tkeep also yields min(cnt,N).
   for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign m_axis_tkeep[gi]        = (CW'(gi) < r_cnt);
      assign m_axis_tdata[8*gi +: 8] = (CW'(gi) < r_cnt) ? r_buf[gi] : 8'h00;
   end

   // Compact the kept input lanes into ascending positions 0..in_n-1.
   always_comb begin
      int idx;
      idx = 0;
      for (int k = 0; k < N; k++) begin
         w_pack[k] = 8'h00;
      end
      for (int i = 0; i < N; i++) begin
         if (s_axis_tkeep[i]) begin
            w_pack[PW'(idx)] = s_axis_tdata[8*i +: 8];
            idx = idx + 1;
         end
      end
      w_in_n = CW'(idx);
   end

   // Shift out the fired bytes and append the compacted input after what remains.
   always_comb begin
      logic [CW-1:0] v_off;
      for (int j = 0; j < B; j++) begin
         w_buf_next[j] = 8'h00;
         v_off         = CW'(j) - w_base;
         if (CW'(j) < w_base) begin
            w_buf_next[j] = r_buf[AW'(CW'(j) + w_shift)];
         end else if (w_accept && (v_off < w_in_n)) begin
            w_buf_next[j] = w_pack[PW'(v_off)];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_cnt  <= '0;
         r_last <= 1'b0;
         for (int k = 0; k < B; k++) begin
            r_buf[k] <= 8'h00;
         end
      end else begin
         r_cnt <= w_base + (w_accept ? w_in_n : '0);
         for (int k = 0; k < B; k++) begin
            r_buf[k] <= w_buf_next[k];
         end
         if (w_fire && m_axis_tlast) begin
            r_last <= 1'b0;
         end else if (w_accept && s_axis_tlast) begin
            r_last <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axis_keep_packer.sv
// Directed bench for axis_keep_packer with N=4: each vector has hand-computed
// output beats; inputs change and outputs are sampled on the falling edge.
module tb_axis_keep_packer;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic [3:0]  s_axis_tkeep = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;

   int checks = 0;
   int failures = 0;

   axis_keep_packer #(.TDATA_WIDTH(32)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Present one input beat (called at a falling edge) and hold it until accepted.
   task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (n == 50) check("push_timeout", 32'(s_axis_tready), 32'd1);
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
   endtask

   // Accept one output beat and compare it against the expected contents.
   task automatic pop(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      m_axis_tready = 1'b1;
      n = 0;
      while (!m_axis_tvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      check({tag, "_valid"}, 32'(m_axis_tvalid), 32'd1);
      check({tag, "_data"},  m_axis_tdata, d);
      check({tag, "_keep"},  32'(m_axis_tkeep), 32'(k));
      check({tag, "_last"},  32'(m_axis_tlast), 32'(l));
      @(negedge aclk);
      m_axis_tready = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
      check({tag, "_tdata"},  m_axis_tdata, 32'd0);
      check({tag, "_tkeep"},  32'(m_axis_tkeep), 32'd0);
      check({tag, "_tlast"},  32'(m_axis_tlast), 32'd0);
   endtask

   initial begin
      // Reset held for two edges, checked during and after.
      aresetn = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      check_idle("rst_during");
      aresetn = 1'b1;
      @(negedge aclk);
      check_idle("rst_after");
      check("rst_cnt", 32'(dut.r_cnt), 32'd0);

      // Two half beats joined into one full last beat.
      push(32'hAABB2211, 4'b0011, 1'b0);
      check("join_no_early_valid", 32'(m_axis_tvalid), 32'd0);
      push(32'h4433CCDD, 4'b1100, 1'b1);
      check("join_tready_blocked", 32'(s_axis_tready), 32'd0);
      pop("join", 32'h44332211, 4'b1111, 1'b1);
      check("join_tready_back", 32'(s_axis_tready), 32'd1);

      // Sparse single beat.
      push(32'h00CC00AA, 4'b0101, 1'b1);
      pop("sparse", 32'h0000CCAA, 4'b0011, 1'b1);

      // 3+3 bytes: one full beat then a partial last beat.
      push(32'hEE332211, 4'b0111, 1'b0);
      push(32'h665544EE, 4'b1110, 1'b1);
      pop("split0", 32'h44332211, 4'b1111, 1'b0);
      pop("split1", 32'h00006655, 4'b0011, 1'b1);

      // Backpressure: two full beats fill the buffer and stall the input.
      m_axis_tready = 1'b0;
      push(32'h03020100, 4'b1111, 1'b0);
      push(32'h07060504, 4'b1111, 1'b0);
      check("bp_tready_low", 32'(s_axis_tready), 32'd0);
      check("bp_cnt8", 32'(dut.r_cnt), 32'd8);
      check("bp_hold_data", m_axis_tdata, 32'h03020100);
      pop("bp0", 32'h03020100, 4'b1111, 1'b0);
      pop("bp1", 32'h07060504, 4'b1111, 1'b0);
      push(32'h0B0A0908, 4'b1111, 1'b0);
      push(32'h0F0E0D0C, 4'b1111, 1'b0);
      pop("bp2", 32'h0B0A0908, 4'b1111, 1'b0);
      pop("bp3", 32'h0F0E0D0C, 4'b1111, 1'b0);

      // Null last beat closes the packet with an empty tlast beat.
      push(32'h12345678, 4'b0000, 1'b1);
      pop("nulllast", 32'h00000000, 4'b0000, 1'b1);
      check("nulllast_tready", 32'(s_axis_tready), 32'd1);

      // Reset with 6 bytes buffered discards them.
      push(32'h13121110, 4'b1111, 1'b0);
      push(32'hEEEE1514, 4'b0011, 1'b0);
      check("mid_cnt6", 32'(dut.r_cnt), 32'd6);
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      check_idle("mid_rst");
      check("mid_cnt0", 32'(dut.r_cnt), 32'd0);
      m_axis_tready = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      check("mid_no_beat", 32'(m_axis_tvalid), 32'd0);
      m_axis_tready = 1'b0;
      push(32'hB2EEB1EE, 4'b1010, 1'b1);
      pop("mid_next", 32'h0000B2B1, 4'b0011, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
